gcd_engine: RTL
===============

Name: gcd_engine

Overview:
- Parametrised hardware GCD coprocessor. It replaces the software subtract-loop GCD routine that runs on the pipelined CPU.
- Takes two unsigned operands through a start/done handshake and computes the GCD iteratively, one step per clock.
- Mode 0 is the subtractive algorithm. Mode 1 is binary (Stein) GCD.
- Reports the iteration count, a zero-operand error and a watchdog timeout. Sits beside the CPU's MEM stage as a memory-mapped accelerator.

Parameters:
- WIDTH, 32, operand and result width in bits.
- ITER_W, 32, width of the iteration counter.
- MAX_ITERS, 2**ITER_W-1, watchdog limit on iterations. Must be ≥1.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  1  0 = subtractive, 1 = binary; latched with start.
- a_in  input  WIDTH  operand A; latched with start.
- b_in  input  WIDTH  operand B; latched with start.
- busy  output  1  high from the edge that accepts start until the edge entering IDLE.
- done  output  1  one-cycle pulse; result and flags are valid from this cycle.
- result  output  WIDTH  GCD; held until the next accepted start.
- iters  output  ITER_W  number of update steps taken; held with result.
- err_zero  output  1  an operand was 0; held with result.
- err_timeout  output  1  MAX_ITERS reached without finishing; held with result.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst). All state and outputs are registered.
- Reset values: state = IDLE; busy, done, err_zero, err_timeout = 0; result = 0; iters = 0. Reset overrides everything, including mid-computation; no partial result survives.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge E0: latch A=a_in, B=b_in, mode; clear iters, k (binary shift count), err_zero, err_timeout, result; busy=1.
  - If a_in==0 or b_in==0: go straight to DONE at E0 with err_zero=1 and result=0.
  - Otherwise go to RUN.
- RUN, subtractive, one decision per edge, in this priority:
  - A==B → result=A, go DONE.
  - A==1 or B==1 → result=1, go DONE.
  - iters==MAX_ITERS → err_timeout=1, result=0, go DONE.
  - Otherwise: if A>B then A=A-B, else B=B-A; iters+1.
- RUN, binary, one decision per edge, in this priority:
  - A==B → result=A<<k, go DONE.
  - A==1 or B==1 → result=1<<k, go DONE.
  - Timeout, as in subtractive mode.
  - Both even → A>>=1, B>>=1, k+1.
  - A even → A>>=1.
  - B even → B>>=1.
  - A>B → A=(A-B)>>1.
  - Otherwise → B=(B-A)>>1.
  - Every non-terminating step increments iters.
  - k needs clog2(WIDTH)+1 bits; the shift cannot overflow because result ≤ min(a_in, b_in).
- DONE: the edge entering DONE sets done=1. The next edge clears done and busy and returns to IDLE.
  - For a nonzero, non-timeout run, done rises at edge E0+iters+1.
  - A start sampled while busy, including in the DONE cycle, is ignored; it is not queued.
  - If start is held high, the next operation is accepted in the first IDLE cycle.
- Arithmetic is unsigned and never underflows, because subtraction is always larger minus smaller. Operand registers are WIDTH bits.
- The iters counter saturates at MAX_ITERS; the timeout check guarantees this.

Test Plan:
1. mode=0, a=9, b=3, start at E0 → busy from E0; A,B = 6,3 then 3,3; done pulse at E3 with result=3, iters=2, no errors; busy low after E4.
2. mode=1, a=12, b=8 → 6,4 (k=1); 3,2 (k=2); 3,1; done at E4 with result=4, iters=3.
3. mode=0, a=0, b=5 → done at E0 edge, err_zero=1, result=0, iters=0. Repeat with a=5, b=0 and with a=0, b=0 → identical response.
4. mode=0, a=7, b=7 → done at E1, result=7, iters=0. Then a=1, b=9 → result=1, iters=0.
5. MAX_ITERS=4, mode=0, a=100, b=3 → after 4 subtractions A=88; done at E5 with err_timeout=1, result=0, iters=4.
6. Interference and reset:
   - During test 1, pulse start with a=20, b=4 at E1 → ignored; result stays 3.
   - Start test 1 again, assert rst at E2 → next cycle: IDLE, busy=0, done=0, result=0, iters=0.
   - A subsequent start of (12,8) in mode 1 completes exactly as in test 2.

Source files
------------

// File: rtl/gcd_engine.sv
// gcd_engine: iterative GCD coprocessor with a start/done handshake.
// Mode 0 is the subtractive algorithm and mode 1 is binary (Stein) GCD.
// Each RUN cycle makes exactly one decision. The engine reports the step
// count, a zero-operand error and a watchdog timeout.
module gcd_engine #(
    parameter int                WIDTH     = 32,
    parameter int                ITER_W    = 32,
    parameter logic [ITER_W-1:0] MAX_ITERS = '1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  result,
    output logic [ITER_W-1:0] iters,
    output logic              err_zero,
    output logic              err_timeout
);

    // Shift count for common factors of two. It never exceeds log2 of the operand.
    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               mode_q, mode_d;
    logic [KW-1:0]      k_q, k_d;
    logic               busy_d, done_d;
    logic [WIDTH-1:0]   result_d;
    logic [ITER_W-1:0]  iters_d;
    logic               err_zero_d, err_timeout_d;

    logic a_even, b_even, a_gt_b;
    assign a_even = ~a_q[0];
    assign b_even = ~b_q[0];
    assign a_gt_b = (a_q > b_q);

    // Next-state and next-output decision: one GCD step, termination, or handshake.
    always_comb begin
        // NOTE: every signal gets its hold value first. A path through the case
        // that leaves a signal unassigned would otherwise infer a latch.
        state_d       = state_q;
        a_d           = a_q;
        b_d           = b_q;
        mode_d        = mode_q;
        k_d           = k_q;
        busy_d        = busy;
        done_d        = 1'b0;
        result_d      = result;
        iters_d       = iters;
        err_zero_d    = err_zero;
        err_timeout_d = err_timeout;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d           = a_in;
                    b_d           = b_in;
                    mode_d        = mode;
                    k_d           = '0;
                    iters_d       = '0;
                    err_zero_d    = 1'b0;
                    err_timeout_d = 1'b0;
                    result_d      = '0;
                    busy_d        = 1'b1;
                    if (a_in == '0 || b_in == '0) begin
                        err_zero_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (a_q == b_q) begin
                    // In subtractive mode k stays 0, so one expression covers both modes.
                    result_d = a_q << k_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (a_q == WIDTH'(1) || b_q == WIDTH'(1)) begin
                    result_d = WIDTH'(1) << k_q;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end else if (iters == MAX_ITERS) begin
                    err_timeout_d = 1'b1;
                    result_d      = '0;
                    done_d        = 1'b1;
                    state_d       = DONE;
                end else begin
                    iters_d = iters + ITER_W'(1);
                    if (!mode_q) begin
                        // Always subtract the smaller value from the larger, so no underflow.
                        if (a_gt_b) a_d = a_q - b_q;
                        else        b_d = b_q - a_q;
                    end else if (a_even && b_even) begin
                        a_d = a_q >> 1;
                        b_d = b_q >> 1;
                        k_d = k_q + KW'(1);
                    end else if (a_even) begin
                        a_d = a_q >> 1;
                    end else if (b_even) begin
                        b_d = b_q >> 1;
                    end else if (a_gt_b) begin
                        a_d = (a_q - b_q) >> 1;
                    end else begin
                        b_d = (b_q - a_q) >> 1;
                    end
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // State and output registers. Reset is synchronous and clears everything,
    // so no partial result survives it.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments. All registers
        // then update together from the values before the edge.
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= 1'b0;
            k_q         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            iters       <= '0;
            err_zero    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            k_q         <= k_d;
            busy        <= busy_d;
            done        <= done_d;
            result      <= result_d;
            iters       <= iters_d;
            err_zero    <= err_zero_d;
            err_timeout <= err_timeout_d;
        end
    end

endmodule
